inst_fetch_ctrl: RTL
====================

// Module: inst_fetch_ctrl
// PURPOSE
//  Initiator side of the instruction-memory interface and producer into IF_ID.
//  Holds the PC, issues one read at a time to inst_rom via req/gnt/rvalid, and
//  presents {pc, inst} to IF_ID with valid/ready.
//  Accepts ID-stage feedback: redirect (branch/jump target, delay slot kept) and
//  flush (kill everything, restart at flush_pc).
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset
//  AW        32             address/PC width
// PORTS
//  clk             in   1   single clock, rising edge
//  rst             in   1   asynchronous, active-high reset
//  imem_req        out  1   read request, held until imem_gnt
//  imem_addr       out  AW  word address, [1:0] always 2'b00
//  imem_gnt        in   1   request accepted this cycle
//  imem_rvalid     in   1   read data valid, >=1 cycle after gnt
//  imem_rdata      in   32  instruction word
//  out_valid       out  1   {out_pc,out_inst} valid toward IF_ID
//  out_pc          out  AW  PC of out_inst
//  out_inst        out  32  instruction
//  out_ready       in   1   IF_ID accepts (0 = ID stall)
//  redirect_valid  in   1   1-cycle pulse: next un-granted fetch goes to redirect_pc
//  redirect_pc     in   AW  branch/jump target
//  flush_valid     in   1   1-cycle pulse: discard buffered + in-flight, restart
//  flush_pc        in   AW  restart address
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=IDLE, imem_req=0, out_valid=0, out_pc=0, out_inst=0,
//   discard=0, redirect_pending=0. First cycle after rst falls: IDLE->REQ.
//  States: IDLE, REQ, WAIT, FULL. At most one outstanding read.
//  REQ: imem_req=1, imem_addr=pc. gnt -> WAIT, pc<=pc+4 (wraps FFFF_FFFC->0).
//  WAIT: rvalid & !discard -> out_pc<=issued addr, out_inst<=rdata, out_valid<=1,
//   ->FULL. rvalid & discard -> drop, discard<=0, ->REQ.
//  FULL: out_valid=1, data stable while !out_ready. out_ready=1: entry consumed;
//   same cycle imem_req=1 (next pc); gnt ->WAIT else ->REQ; out_valid<=0.
//  Throughput: 1 instr / 2 cycles with 1-cycle memory and out_ready=1.
//  Redirect: pc<=redirect_pc&~3 (overrides pc+4 if gnt in same cycle). Request
//   granted before/at redirect still delivered (delay slot). Buffered entry kept.
//  Flush (priority over redirect): pc<=flush_pc&~3; out_valid<=0 next cycle;
//   in WAIT or REQ-with-gnt -> WAIT with discard=1; else ->REQ. Flush with
//   out_ready same cycle: entry dropped (IF_ID also flushes).
//  rvalid in IDLE/REQ/FULL (stale, e.g. after reset mid-read): ignored.
//  rst asserted mid-operation: all state to reset values immediately, async.
//  imem_addr stable and imem_req held while waiting for gnt (no retraction,
//   except flush/redirect may change addr only while gnt=0).
// STRUCTURE
//  Package mips_defs: fetch_state_t enum {IDLE,REQ,WAIT,FULL}, RESET_PC default,
//   INST_W=32, PC_INC=4.
//  Sub-module fetch_pc_reg: PC register with inc/redirect/flush mux and priority;
//   FSM, discard flag and output buffer stay in inst_fetch_ctrl.
// TESTING
//  1 Reset, 1-cycle mem, out_ready=1 -> pcs 0,4,8,C on out_pc every 2 cycles.
//  2 out_ready=0 for 5 cycles in FULL -> out_valid=1, out_pc/out_inst stable,
//    imem_req=0; release -> next pc requested same cycle.
//  3 redirect_valid (0x100) same cycle as gnt for pc=8 -> instr@8 delivered,
//    next request addr=0x100, then 0x104.
//  4 flush_valid(0x80) in WAIT, rvalid 3 cycles later -> that data dropped,
//    out_valid stays 0, next request addr=0x80.
//  5 flush and redirect same cycle -> flush wins; redirect_pc=0x3 -> addr 0x0.
//  6 rst pulsed mid-WAIT, stale rvalid after release -> ignored, first out_pc=RESET_PC.

Source files
------------

// File: rtl/mips_defs.sv
// Shared fetch-side definitions: state encoding, widths and the default reset PC.
package mips_defs;

  localparam int INST_W = 32;
  localparam int PC_INC = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Next-fetch PC register. Flush beats redirect beats the post-grant increment.
module fetch_pc_reg
  import mips_defs::*;
#(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_en,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  input  logic          flush_valid,
  input  logic [AW-1:0] flush_pc,
  output logic [AW-1:0] pc_q
);

  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

  logic [AW-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (flush_valid) begin
      pc_d = flush_pc & ALIGN_MASK;
    end else if (redirect_valid) begin
      pc_d = redirect_pc & ALIGN_MASK;
    end else if (inc_en) begin
      pc_d = pc_q + AW'(PC_INC);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch initiator: one outstanding imem read, single-entry buffer toward IF_ID.
//
// state | meaning
// IDLE  | first cycle after reset, nothing issued
// REQ   | imem_req high at pc, waiting for gnt
// WAIT  | read granted, waiting for rvalid (discard set -> drop it)
// FULL  | entry buffered toward IF_ID, next fetch issued once out_ready
module inst_fetch_ctrl
  import mips_defs::*;
#(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [AW-1:0]     imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              out_valid,
  output logic [AW-1:0]     out_pc,
  output logic [INST_W-1:0] out_inst,
  input  logic              out_ready,
  input  logic              redirect_valid,
  input  logic [AW-1:0]     redirect_pc,
  input  logic              flush_valid,
  input  logic [AW-1:0]     flush_pc
);

  fetch_state_t      state_q, state_d;
  logic              discard_q, discard_d;
  logic              out_valid_q, out_valid_d;
  logic [AW-1:0]     out_pc_q, out_pc_d;
  logic [INST_W-1:0] out_inst_q, out_inst_d;
  logic [AW-1:0]     issued_q, issued_d;
  logic [AW-1:0]     pc_q;
  logic              issue;

  fetch_pc_reg #(
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk            (clk),
    .rst            (rst),
    .inc_en         (issue),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_valid    (flush_valid),
    .flush_pc       (flush_pc),
    .pc_q           (pc_q)
  );

  assign issue     = imem_req & imem_gnt;
  assign imem_addr = {pc_q[AW-1:2], 2'b00};
  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_inst  = out_inst_q;

  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    issued_d    = issued_q;
    imem_req    = 1'b0;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else begin
            out_pc_d    = issued_q;
            out_inst_d  = imem_rdata;
            out_valid_d = 1'b1;
            state_d     = FULL;
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          imem_req    = 1'b1;
          out_valid_d = 1'b0;
          state_d     = imem_gnt ? WAIT : REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) issued_d = pc_q;

    // A read still in flight after the flush must be drained before refetching.
    if (flush_valid) begin
      out_valid_d = 1'b0;
      if (issue || (state_q == WAIT && !imem_rvalid)) begin
        state_d   = WAIT;
        discard_d = 1'b1;
      end else begin
        state_d   = REQ;
        discard_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      discard_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
      issued_q    <= '0;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      issued_q    <= issued_d;
    end
  end

endmodule
